hazard_forward_pipe: RTL and testbench
======================================

Name: hazard_forward_pipe

Overview:
Parametrised successor to the combinational operand-forwarding selector. It tracks in-flight register writers in a shift-register scoreboard spanning NUM_STAGES post-ID stages and detects load-use hazards in ID. It raises a stall and registers per-operand forward selects into EX, so EX needs no comparators. It sits beside the ID/EX pipeline register and drives the EX operand muxes.

Parameters:
NUM_STAGES, 3, tracked stages after ID (0=EX, 1=MEM, 2=WB, ...); range 2..6
LOAD_READY, 2, first stage index at which load data is forwardable; range 1..NUM_STAGES-1
REG_AW, 5, register address width
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
id_valid  in  1  valid instruction in ID
id_rs1  in  REG_AW  ID source 1
id_rs2  in  REG_AW  ID source 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  ID destination
id_reg_write  in  1  instruction writes rd
id_kind  in  2  result kind: 0 ALU, 1 LOAD, 2 PC+4, 3 IMM
pipe_hold  in  1  global freeze (memory wait)
flush  in  1  kill the instruction in ID (branch taken in EX)
stall  out  1  load-use stall request to IF/ID (combinational)
ex_fwd_a_sel  out  clog2(NUM_STAGES)+1  operand A source: 0 register file, k = stage k result
ex_fwd_a_kind  out  2  kind of the selected producer (selects ALU/load/PC+4/imm field)
ex_fwd_b_sel  out  clog2(NUM_STAGES)+1  same for operand B
ex_fwd_b_kind  out  2  same for operand B
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset is synchronous (rstn=0 at posedge). It clears all scoreboard entries, all ex_fwd_* outputs to 0, and stall_cnt to 0. stall is 0 while all entries are invalid.
- Each scoreboard entry e[k] for k = 0..NUM_STAGES-1 holds {valid, rd, kind}. Entries with rd=0 or reg_write=0 are stored as invalid.
- Operand lookup in ID, done independently for rs1 and rs2:
  - Find the lowest k with e[k].valid and e[k].rd == rs.
  - The producer will be at stage k+1 when the consumer reaches EX.
  - If no match, if rs==0, or if use=0: sel=0, kind=0.
  - If k+1 > NUM_STAGES-1: the producer has retired, and the register file must be write-through, so sel=0.
  - If kind==LOAD and k+1 < LOAD_READY: hazard. The lookup never falls back to an older match.
  - Otherwise: sel = k+1, kind = e[k].kind.
- stall = id_valid & (hazard_a | hazard_b). It is combinational, with same-cycle visibility to the fetch/decode control.
- issue = id_valid & ~stall & ~pipe_hold & ~flush.
- On each posedge with pipe_hold=0:
  - e[k] <= e[k-1] for k ≥ 1.
  - e[0] <= issue ? {id_reg_write & (id_rd≠0), id_rd, id_kind} : bubble.
  - ex_fwd_* <= issue ? lookup results : 0.
- pipe_hold=1 freezes entries, ex_fwd_* and stall_cnt. stall is still computed.
- Latency: lookup happens in ID and is visible on ex_fwd_* exactly one cycle after issue. A load followed immediately by a dependent instruction costs LOAD_READY-1 stall cycles.
- Simultaneous flush and stall: flush wins. A bubble enters, and stall_cnt still increments if stall=1.
- stall_cnt increments when stall & ~pipe_hold, and saturates at all-ones.
- rstn=0 mid-stall drops stall on the next cycle; no stale entries survive.

Decomposition:
- Shared include hazard_defs.vh holds:
  - KIND_ALU=0, KIND_LOAD=1, KIND_PC4=2, KIND_IMM=3
  - the select-width macro
- One sub-module, hazard_src_lookup: purely combinational, instantiated twice (rs1, rs2). Parameters NUM_STAGES, LOAD_READY, REG_AW. It takes the flattened entries and returns {sel, kind, hazard}.
- Top level contains the shift register, issue logic, output registers and counter.

Test Plan:
1. Reset with rstn=0 for 2 cycles, then issue add x5 followed by add x6,x5,x1 → second op has ex_fwd_a_sel=1, kind=0 (ALU), stall never asserted.
2. lw x5 then add x7,x0,x5 with defaults → stall=1 for exactly 1 cycle, stall_cnt=1; then ex_fwd_b_sel=2, ex_fwd_b_kind=1.
3. Writes to x3 at stage 0 (ALU) and stage 1 (LOAD), then consumer reads x3 → sel=1, kind=0 (youngest wins, no stall). A consumer reading x0 after a write to x0 gets sel=0.
4. LOAD_READY=3, NUM_STAGES=4: lw x9 followed immediately by use of x9 → 2 stall cycles, then sel=3.
5. During a load-use stall, assert flush and pipe_hold in separate runs:
   - flush → bubble enters, ex_fwd_*=0.
   - pipe_hold → entries and ex_fwd_* unchanged, stall_cnt frozen.
6. Force stall_cnt to all-ones (CNT_W=4, 16 stall cycles) → it stays at 15. A jal x1 producer (kind 2) followed by use of x1 → kind=2, sel=1.

Source files
------------

// File: rtl/hazard_forward_pipe_pkg.sv
// hazard_forward_pipe_pkg: result kinds and forward-select width shared by the hazard unit
package hazard_forward_pipe_pkg;
   localparam logic [1:0] KIND_ALU  = 2'd0;
   localparam logic [1:0] KIND_LOAD = 2'd1;
   localparam logic [1:0] KIND_PC4  = 2'd2;
   localparam logic [1:0] KIND_IMM  = 2'd3;
   function automatic int sel_w(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/hazard_forward_pipe_src_lookup.sv
// hazard_src_lookup: youngest-producer search for one ID source operand
module hazard_src_lookup
   import hazard_forward_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_READY = 2,
   parameter int REG_AW     = 5,
   localparam int SW        = sel_w(NUM_STAGES),
   localparam int EW        = REG_AW + 3
) (
   input  logic [NUM_STAGES*EW-1:0] ent,
   input  logic [REG_AW-1:0]        rs,
   input  logic                     use_rs,
   output logic [SW-1:0]            sel,
   output logic [1:0]               kind,
   output logic                     hazard
);
   logic          hit, live;
   logic [EW-1:0] e;
   int            idx;
   always_comb begin
      hit = 1'b0;
      idx = 0;
      for (int k = NUM_STAGES - 1; k >= 0; k--)
         if (ent[k*EW+EW-1] && ent[k*EW+2 +: REG_AW] == rs) begin
            hit = 1'b1;
            idx = k;
         end
      e      = ent[idx*EW +: EW];
      live   = use_rs && rs != '0 && hit;
      // a too-young load blocks the operand; older matches are never consulted
      hazard = live && e[1:0] == KIND_LOAD && idx + 1 < LOAD_READY;
      sel    = (live && !hazard && idx + 1 <= NUM_STAGES - 1) ? SW'(idx + 1) : '0;
      kind   = sel != '0 ? e[1:0] : 2'd0;
   end
endmodule

// File: rtl/hazard_forward_pipe.sv
// hazard_forward_pipe: in-flight writer scoreboard, load-use stall and registered EX forward selects
module hazard_forward_pipe
   import hazard_forward_pipe_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_READY = 2,
   parameter int REG_AW     = 5,
   parameter int CNT_W      = 32,
   localparam int SW        = sel_w(NUM_STAGES)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic [1:0]        id_kind,
   input  logic              pipe_hold,
   input  logic              flush,
   output logic              stall,
   output logic [SW-1:0]     ex_fwd_a_sel,
   output logic [1:0]        ex_fwd_a_kind,
   output logic [SW-1:0]     ex_fwd_b_sel,
   output logic [1:0]        ex_fwd_b_kind,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam int EW = REG_AW + 3;
   logic [NUM_STAGES*EW-1:0] ent;
   logic [SW-1:0]            sel_a, sel_b;
   logic [1:0]               kind_a, kind_b;
   logic                     haz_a, haz_b, issue;
   hazard_src_lookup #(.NUM_STAGES(NUM_STAGES), .LOAD_READY(LOAD_READY), .REG_AW(REG_AW)) u_a (
      .ent(ent), .rs(id_rs1), .use_rs(id_use_rs1), .sel(sel_a), .kind(kind_a), .hazard(haz_a)
   );
   hazard_src_lookup #(.NUM_STAGES(NUM_STAGES), .LOAD_READY(LOAD_READY), .REG_AW(REG_AW)) u_b (
      .ent(ent), .rs(id_rs2), .use_rs(id_use_rs2), .sel(sel_b), .kind(kind_b), .hazard(haz_b)
   );
   assign stall = id_valid & (haz_a | haz_b);
   assign issue = id_valid & ~stall & ~pipe_hold & ~flush;
   always_ff @(posedge clk)
      if (!rstn) begin
         ent           <= '0;
         ex_fwd_a_sel  <= '0;
         ex_fwd_a_kind <= '0;
         ex_fwd_b_sel  <= '0;
         ex_fwd_b_kind <= '0;
         stall_cnt     <= '0;
      end else if (!pipe_hold) begin
         ent           <= {ent[(NUM_STAGES-1)*EW-1:0],
                           issue ? {id_reg_write & (id_rd != '0), id_rd, id_kind} : EW'(0)};
         ex_fwd_a_sel  <= issue ? sel_a : '0;
         ex_fwd_a_kind <= issue ? kind_a : 2'd0;
         ex_fwd_b_sel  <= issue ? sel_b : '0;
         ex_fwd_b_kind <= issue ? kind_b : 2'd0;
         if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
endmodule

// File: tb/tb_hazard_forward_pipe.sv
// tb_hazard_forward_pipe: scoreboard bench over default, deep-load and narrow-counter configurations
module tb_hazard_forward_pipe;
   import hazard_forward_pipe_pkg::*;
   logic       clk = 1'b0, rstn = 1'b1;
   logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, pipe_hold, flush;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [1:0] id_kind;
   logic       stall0, stall1, stall2;
   logic [2:0] as0, bs0, as1, bs1, as2, bs2;
   logic [1:0] ak0, bk0, ak1, bk1, ak2, bk2;
   logic [31:0] cnt0, cnt1;
   logic [3:0] cnt2;
   int tests = 0, fails = 0;

   typedef struct packed {logic [2:0] a_sel; logic [1:0] a_kind; logic [2:0] b_sel; logic [1:0] b_kind;} fwd_t;
   typedef struct packed {
      logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
      logic [4:0] rd; logic rw; logic [1:0] k; logic hold; logic fl; logic st; fwd_t f;
   } row_t;
   fwd_t sbq[$];

   always #5 clk = ~clk;

   hazard_forward_pipe u0 (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_kind(id_kind), .pipe_hold(pipe_hold), .flush(flush), .stall(stall0),
      .ex_fwd_a_sel(as0), .ex_fwd_a_kind(ak0), .ex_fwd_b_sel(bs0), .ex_fwd_b_kind(bk0), .stall_cnt(cnt0)
   );
   hazard_forward_pipe #(.NUM_STAGES(4), .LOAD_READY(3)) u1 (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_kind(id_kind), .pipe_hold(pipe_hold), .flush(flush), .stall(stall1),
      .ex_fwd_a_sel(as1), .ex_fwd_a_kind(ak1), .ex_fwd_b_sel(bs1), .ex_fwd_b_kind(bk1), .stall_cnt(cnt1)
   );
   hazard_forward_pipe #(.CNT_W(4)) u2 (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_kind(id_kind), .pipe_hold(pipe_hold), .flush(flush), .stall(stall2),
      .ex_fwd_a_sel(as2), .ex_fwd_a_kind(ak2), .ex_fwd_b_sel(bs2), .ex_fwd_b_kind(bk2), .stall_cnt(cnt2)
   );

   function automatic row_t mk(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] rd, input logic rw, input logic [1:0] k,
                               input logic hold, input logic fl, input logic st, input logic [2:0] sa,
                               input logic [1:0] ka, input logic [2:0] sb, input logic [1:0] kb);
      row_t x;
      x = {v, rs1, u1, rs2, u2, rd, rw, k, hold, fl, st, sa, ka, sb, kb};
      return x;
   endfunction

   task automatic apply(input row_t x);
      id_valid = x.v; id_rs1 = x.rs1; id_use_rs1 = x.u1; id_rs2 = x.rs2; id_use_rs2 = x.u2;
      id_rd = x.rd; id_reg_write = x.rw; id_kind = x.k; pipe_hold = x.hold; flush = x.fl;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rstn = 1'b0;
      apply(mk(1, 5'd3, 1, 5'd4, 1, 5'd5, 1, KIND_LOAD, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) tick;
      apply(mk(0, 0, 0, 0, 0, 0, 0, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      rstn = 1'b1;
   endtask

   task automatic test_reset;
      do_reset;
      tests++;
      if ({as0, ak0, bs0, bk0} !== 10'd0) begin
         fails++; $display("FAIL reset_fwd got %h expected 000", {as0, ak0, bs0, bk0});
      end
      tests++;
      if (cnt0 !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d expected 0", cnt0); end
      tests++;
      if (stall0 !== 1'b0) begin fails++; $display("FAIL reset_stall got %b expected 0", stall0); end
   endtask

   task automatic test_alu_forward;
      row_t rows[$];
      fwd_t e;
      do_reset;
      rows.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, KIND_ALU, 0, 0, 0, 1, KIND_ALU, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         tests++;
         if (stall0 !== rows[i].st) begin fails++; $display("FAIL alu_fwd_stall row %0d got %b expected %b", i, stall0, rows[i].st); end
         sbq.push_back(rows[i].f);
         tick;
         e = sbq.pop_front();
         tests++;
         if ({as0, ak0, bs0, bk0} !== e) begin fails++; $display("FAIL alu_fwd row %0d got %h expected %h", i, {as0, ak0, bs0, bk0}, e); end
      end
      tests++;
      if (cnt0 !== 32'd0) begin fails++; $display("FAIL alu_fwd_cnt got %0d expected 0", cnt0); end
   endtask

   task automatic test_load_use;
      row_t rows[$];
      fwd_t e;
      do_reset;
      rows.push_back(mk(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, KIND_LOAD, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd0, 1, 5'd5, 1, 5'd7, 1, KIND_ALU, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd0, 1, 5'd5, 1, 5'd7, 1, KIND_ALU, 0, 0, 0, 0, 0, 2, KIND_LOAD));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         tests++;
         if (stall0 !== rows[i].st) begin fails++; $display("FAIL load_use_stall row %0d got %b expected %b", i, stall0, rows[i].st); end
         sbq.push_back(rows[i].f);
         tick;
         e = sbq.pop_front();
         tests++;
         if ({as0, ak0, bs0, bk0} !== e) begin fails++; $display("FAIL load_use row %0d got %h expected %h", i, {as0, ak0, bs0, bk0}, e); end
      end
      tests++;
      if (cnt0 !== 32'd1) begin fails++; $display("FAIL load_use_cnt got %0d expected 1", cnt0); end
   endtask

   task automatic test_youngest;
      row_t rows[$];
      fwd_t e;
      do_reset;
      rows.push_back(mk(1, 5'd1, 0, 5'd2, 0, 5'd3, 1, KIND_LOAD, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, KIND_ALU, 0, 0, 0, 1, KIND_ALU, 1, KIND_ALU));
      rows.push_back(mk(1, 5'd1, 0, 5'd2, 0, 5'd0, 1, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         tests++;
         if (stall0 !== rows[i].st) begin fails++; $display("FAIL youngest_stall row %0d got %b expected %b", i, stall0, rows[i].st); end
         sbq.push_back(rows[i].f);
         tick;
         e = sbq.pop_front();
         tests++;
         if ({as0, ak0, bs0, bk0} !== e) begin fails++; $display("FAIL youngest row %0d got %h expected %h", i, {as0, ak0, bs0, bk0}, e); end
      end
   endtask

   task automatic test_deep_load;
      row_t rows[$];
      fwd_t e;
      do_reset;
      rows.push_back(mk(1, 5'd1, 0, 5'd0, 0, 5'd9, 1, KIND_LOAD, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, KIND_ALU, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, KIND_ALU, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, KIND_ALU, 0, 0, 0, 3, KIND_LOAD, 0, 0));
      rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         tests++;
         if (stall1 !== rows[i].st) begin fails++; $display("FAIL deep_load_stall row %0d got %b expected %b", i, stall1, rows[i].st); end
         sbq.push_back(rows[i].f);
         tick;
         e = sbq.pop_front();
         tests++;
         if ({as1, ak1, bs1, bk1} !== e) begin fails++; $display("FAIL deep_load row %0d got %h expected %h", i, {as1, ak1, bs1, bk1}, e); end
      end
      tests++;
      if (cnt1 !== 32'd2) begin fails++; $display("FAIL deep_load_cnt got %0d expected 2", cnt1); end
   endtask

   task automatic test_flush;
      row_t rows[$];
      fwd_t e;
      do_reset;
      rows.push_back(mk(1, 5'd1, 0, 5'd0, 0, 5'd5, 1, KIND_LOAD, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd0, 0, 5'd5, 1, 5'd7, 1, KIND_ALU, 0, 1, 1, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd0, 0, 5'd5, 1, 5'd7, 1, KIND_ALU, 0, 1, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         tests++;
         if (stall0 !== rows[i].st) begin fails++; $display("FAIL flush_stall row %0d got %b expected %b", i, stall0, rows[i].st); end
         sbq.push_back(rows[i].f);
         tick;
         e = sbq.pop_front();
         tests++;
         if ({as0, ak0, bs0, bk0} !== e) begin fails++; $display("FAIL flush row %0d got %h expected %h", i, {as0, ak0, bs0, bk0}, e); end
      end
      tests++;
      if (cnt0 !== 32'd1) begin fails++; $display("FAIL flush_cnt got %0d expected 1", cnt0); end
   endtask

   task automatic test_hold;
      row_t rows[$];
      fwd_t e;
      do_reset;
      rows.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, KIND_LOAD, 0, 0, 0, 1, KIND_ALU, 0, 0));
      rows.push_back(mk(1, 5'd0, 0, 5'd5, 1, 5'd7, 1, KIND_ALU, 1, 0, 1, 1, KIND_ALU, 0, 0));
      rows.push_back(mk(1, 5'd0, 0, 5'd5, 1, 5'd7, 1, KIND_ALU, 1, 0, 1, 1, KIND_ALU, 0, 0));
      rows.push_back(mk(1, 5'd0, 0, 5'd5, 1, 5'd7, 1, KIND_ALU, 0, 0, 1, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd0, 0, 5'd5, 1, 5'd7, 1, KIND_ALU, 0, 0, 0, 0, 0, 2, KIND_LOAD));
      foreach (rows[i]) begin
         apply(rows[i]);
         tests++;
         if (stall0 !== rows[i].st) begin fails++; $display("FAIL hold_stall row %0d got %b expected %b", i, stall0, rows[i].st); end
         sbq.push_back(rows[i].f);
         tick;
         e = sbq.pop_front();
         tests++;
         if ({as0, ak0, bs0, bk0} !== e) begin fails++; $display("FAIL hold row %0d got %h expected %h", i, {as0, ak0, bs0, bk0}, e); end
      end
      tests++;
      if (cnt0 !== 32'd1) begin fails++; $display("FAIL hold_cnt got %0d expected 1", cnt0); end
   endtask

   task automatic test_saturate_and_jal;
      row_t rows[$];
      fwd_t e;
      do_reset;
      // chained dependent loads stall every other cycle
      apply(mk(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, KIND_LOAD, 0, 0, 0, 0, 0, 0, 0));
      repeat (20) tick;
      tests++;
      if (cnt2 !== 4'd10) begin fails++; $display("FAIL sat_mid got %0d expected 10", cnt2); end
      repeat (20) tick;
      tests++;
      if (cnt2 !== 4'hf) begin fails++; $display("FAIL sat_cnt got %0d expected 15", cnt2); end
      tests++;
      if (cnt0 !== 32'd20) begin fails++; $display("FAIL sat_wide got %0d expected 20", cnt0); end
      rows.push_back(mk(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, KIND_PC4, 0, 0, 0, 0, 0, 0, 0));
      rows.push_back(mk(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, KIND_ALU, 0, 0, 0, 1, KIND_PC4, 0, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         tests++;
         if (stall0 !== rows[i].st) begin fails++; $display("FAIL jal_stall row %0d got %b expected %b", i, stall0, rows[i].st); end
         sbq.push_back(rows[i].f);
         tick;
         e = sbq.pop_front();
         tests++;
         if ({as0, ak0, bs0, bk0} !== e) begin fails++; $display("FAIL jal row %0d got %h expected %h", i, {as0, ak0, bs0, bk0}, e); end
      end
   endtask

   task automatic test_reset_mid_stall;
      do_reset;
      apply(mk(1, 5'd1, 0, 5'd0, 0, 5'd5, 1, KIND_LOAD, 0, 0, 0, 0, 0, 0, 0));
      tick;
      apply(mk(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, KIND_ALU, 0, 0, 0, 0, 0, 0, 0));
      tests++;
      if (stall0 !== 1'b1) begin fails++; $display("FAIL mid_stall_pre got %b expected 1", stall0); end
      rstn = 1'b0;
      tick;
      tests++;
      if (stall0 !== 1'b0) begin fails++; $display("FAIL mid_stall_drop got %b expected 0", stall0); end
      rstn = 1'b1;
      tick;
      tests++;
      if ({as0, ak0, bs0, bk0} !== 10'd0) begin fails++; $display("FAIL mid_stall_stale got %h expected 000", {as0, ak0, bs0, bk0}); end
   endtask

   initial begin
      test_reset;
      test_alu_forward;
      test_load_use;
      test_youngest;
      test_deep_load;
      test_flush;
      test_hold;
      test_saturate_and_jal;
      test_reset_mid_stall;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
